// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller and pipeline registers.
package mips_pipe_pkg;

    // Hazard controller FSM states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_e;

    // Architectural zero register; never a real data dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control-bundle bit positions cleared by the pipeline register flush logic.
    localparam int unsigned CTRL_W        = 9;
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_MEMREAD  = 2;
    localparam int unsigned CTRL_MEMWRITE = 3;
    localparam int unsigned CTRL_BRANCH   = 4;
    localparam int unsigned CTRL_ALUSRC   = 5;
    localparam int unsigned CTRL_REGDST   = 6;
    localparam int unsigned CTRL_ALUOP_LO = 7;
    localparam int unsigned CTRL_ALUOP_HI = 8;

    // Enable/flush bundle driven to the pipeline registers.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_flush;
        logic exmem_write;
        logic memwb_flush;
    } hz_ctrl_t;

    // Normal flow: everything advances, nothing squashed.
    function automatic hz_ctrl_t ctrl_run();
        hz_ctrl_t c;
        c.pc_write    = 1'b1;
        c.ifid_write  = 1'b1;
        c.ifid_flush  = 1'b0;
        c.idex_write  = 1'b1;
        c.idex_flush  = 1'b0;
        c.exmem_write = 1'b1;
        c.memwb_flush = 1'b0;
        return c;
    endfunction

    // Whole-pipeline freeze; MEM/WB gets a bubble so WB does not repeat.
    function automatic hz_ctrl_t ctrl_freeze();
        hz_ctrl_t c;
        c.pc_write    = 1'b0;
        c.ifid_write  = 1'b0;
        c.ifid_flush  = 1'b0;
        c.idex_write  = 1'b0;
        c.idex_flush  = 1'b0;
        c.exmem_write = 1'b0;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the load in EX and the instruction in ID.
module load_use_detect
    import mips_pipe_pkg::*;
(
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    output logic       o_load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    // A load into $0 never creates a dependency; rt only matters when ID reads it.
    always_comb begin
        w_rs_hit   = (i_ex_rt == i_id_rs);
        w_rt_hit   = i_id_uses_rt && (i_ex_rt == i_id_rt);
        o_load_use = i_ex_memread && (i_ex_rt != REG_ZERO) && (w_rs_hit || w_rt_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use bubbles, taken-branch squash, memory-wait freeze.
module pipe_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic             EX_branch_taken,
    input  logic             MEM_mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_write,
    output logic             IDEX_flush,
    output logic             EXMEM_write,
    output logic             MEMWB_flush,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WCNT_W = $clog2(WAIT_MAX + 1);

    hz_state_e         r_state;
    hz_state_e         w_state_eff;
    hz_state_e         w_state_nxt;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [WCNT_W-1:0] w_wait_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              w_load_use;
    logic              w_mem_stall;
    logic              w_flush_acc;
    hz_ctrl_t          w_ctrl;

    load_use_detect u_load_use_detect (
        .i_ex_memread (EX_MemRead),
        .i_ex_rt      (EX_rt),
        .i_id_rs      (ID_rs),
        .i_id_rt      (ID_rt),
        .i_id_uses_rt (ID_uses_rt),
        .o_load_use   (w_load_use)
    );

    // Next-state and same-cycle control; reset forces RUN behaviour for current inputs.
    always_comb begin
        w_state_eff = rst ? RUN : r_state;
        w_mem_stall = MEM_mem_req && !mem_ready;
        w_ctrl      = ctrl_run();
        w_state_nxt = w_state_eff;
        w_wait_nxt  = r_wait_cnt;
        w_err_nxt   = r_err;
        w_flush_acc = 1'b0;
        case (w_state_eff)
            RUN: begin
                if (w_mem_stall) begin
                    w_ctrl      = ctrl_freeze();
                    w_state_nxt = MEM_WAIT;
                    w_wait_nxt  = WCNT_W'(1);
                end else if (EX_branch_taken) begin
                    w_ctrl.ifid_flush = 1'b1;
                    w_ctrl.idex_flush = 1'b1;
                    w_flush_acc       = 1'b1;
                end else if (w_load_use) begin
                    w_ctrl.pc_write   = 1'b0;
                    w_ctrl.ifid_write = 1'b0;
                    w_ctrl.idex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    w_state_nxt = RUN;
                end else begin
                    w_ctrl = ctrl_freeze();
                    if (r_wait_cnt == WCNT_W'(WAIT_MAX - 1)) begin
                        w_state_nxt = ERR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_wait_nxt = r_wait_cnt + WCNT_W'(1);
                    end
                end
            end
            ERR: begin
                w_ctrl = ctrl_freeze();
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // State, wait counter, sticky error and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_err      <= w_err_nxt;
            if (!w_ctrl.pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_acc && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_write    = w_ctrl.pc_write;
    assign IFID_write  = w_ctrl.ifid_write;
    assign IFID_flush  = w_ctrl.ifid_flush;
    assign IDEX_write  = w_ctrl.idex_write;
    assign IDEX_flush  = w_ctrl.idex_flush;
    assign EXMEM_write = w_ctrl.exmem_write;
    assign MEMWB_flush = w_ctrl.memwb_flush;
    assign busy        = (w_state_eff == MEM_WAIT);
    assign err         = r_err;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned WMAX = 4;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ID_rs, ID_rt, EX_rt;
    logic          ID_uses_rt, EX_MemRead, EX_branch_taken, MEM_mem_req, mem_ready;
    logic          pc_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush;
    logic          EXMEM_write, MEMWB_flush, busy, err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_waiting;
    int m_waited;
    bit m_dead;
    bit m_err;
    int m_stalls;
    int m_flushes;

    pipe_hazard_ctrl #(.WAIT_MAX(WMAX), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .EX_branch_taken(EX_branch_taken),
        .MEM_mem_req(MEM_mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
        .IDEX_write(IDEX_write), .IDEX_flush(IDEX_flush), .EXMEM_write(EXMEM_write),
        .MEMWB_flush(MEMWB_flush), .busy(busy), .err(err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Compute expected outputs for this cycle, compare, then advance the model past the edge.
    task automatic model_step();
        bit lu, ms, frz, acc;
        int e_pw, e_ifw, e_iff, e_idw, e_idf, e_emw, e_mwf, e_busy;
        lu  = EX_MemRead && (EX_rt != 0) && ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
        ms  = MEM_mem_req && !mem_ready;
        frz = 1'b0;
        acc = 1'b0;
        e_pw = 1; e_ifw = 1; e_iff = 0; e_idw = 1; e_idf = 0; e_emw = 1; e_mwf = 0;
        if (!rst && (m_dead || (m_waiting && !mem_ready))) frz = 1'b1;
        else if (!rst && m_waiting) frz = 1'b0;
        else if (ms) frz = 1'b1;
        else if (EX_branch_taken) begin e_iff = 1; e_idf = 1; acc = 1'b1; end
        else if (lu) begin e_pw = 0; e_ifw = 0; e_idf = 1; end
        if (frz) begin e_pw = 0; e_ifw = 0; e_idw = 0; e_emw = 0; e_mwf = 1; end
        e_busy = (!rst && m_waiting) ? 1 : 0;

        chk("pc_write", int'(pc_write), e_pw);
        chk("IFID_write", int'(IFID_write), e_ifw);
        chk("IFID_flush", int'(IFID_flush), e_iff);
        chk("IDEX_write", int'(IDEX_write), e_idw);
        chk("IDEX_flush", int'(IDEX_flush), e_idf);
        chk("EXMEM_write", int'(EXMEM_write), e_emw);
        chk("MEMWB_flush", int'(MEMWB_flush), e_mwf);
        chk("busy", int'(busy), e_busy);
        chk("err", int'(err), int'(m_err));
        chk("stall_cnt", int'(stall_cnt), m_stalls);
        chk("flush_cnt", int'(flush_cnt), m_flushes);

        if (rst) begin
            m_waiting = 0; m_waited = 0; m_dead = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (e_pw == 0 && m_stalls < CMAX) m_stalls++;
            if (acc && m_flushes < CMAX) m_flushes++;
            if (m_dead) begin
                // stays dead until reset
            end else if (m_waiting) begin
                if (mem_ready) m_waiting = 0;
                else begin
                    m_waited++;
                    if (m_waited >= int'(WMAX)) begin m_dead = 1; m_err = 1; m_waiting = 0; end
                end
            end else if (ms) begin
                m_waiting = 1;
                m_waited  = 1;
            end
        end
    endtask

    task automatic cyc(input bit r, input int rs, input int rt, input bit uses, input bit mrd,
                       input int ert, input bit br, input bit req, input bit rdy);
        @(negedge clk);
        rst = r; ID_rs = 5'(rs); ID_rt = 5'(rt); ID_uses_rt = uses;
        EX_MemRead = mrd; EX_rt = 5'(ert); EX_branch_taken = br;
        MEM_mem_req = req; mem_ready = rdy;
        #1;
        model_step();
    endtask

    task automatic idle();
        cyc(0, 1, 2, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        do_reset();
        idle();
        chk("reset stall_cnt", int'(stall_cnt), 0);
        chk("reset flush_cnt", int'(flush_cnt), 0);
        chk("reset err", int'(err), 0);
        chk("reset busy", int'(busy), 0);

        // Load-use on rs: one bubble
        cyc(0, 8, 3, 0, 1, 8, 0, 0, 1);
        chk("lu pc_write", int'(pc_write), 0);
        chk("lu IFID_write", int'(IFID_write), 0);
        chk("lu IDEX_flush", int'(IDEX_flush), 1);
        idle();
        chk("lu stall_cnt", int'(stall_cnt), 1);

        // $0 and unused-rt filters
        cyc(0, 0, 4, 0, 1, 0, 0, 0, 1);
        chk("zero pc_write", int'(pc_write), 1);
        cyc(0, 3, 9, 0, 1, 9, 0, 0, 1);
        chk("rt unused pc_write", int'(pc_write), 1);
        cyc(0, 3, 9, 1, 1, 9, 0, 0, 1);
        chk("rt used pc_write", int'(pc_write), 0);

        // Branch masks a coincident load-use
        do_reset();
        cyc(0, 8, 0, 0, 1, 8, 1, 0, 1);
        chk("br IFID_flush", int'(IFID_flush), 1);
        chk("br IDEX_flush", int'(IDEX_flush), 1);
        chk("br pc_write", int'(pc_write), 1);
        idle();
        chk("br flush_cnt", int'(flush_cnt), 1);
        chk("br stall_cnt", int'(stall_cnt), 0);

        // Three-cycle memory wait then release
        do_reset();
        cyc(0, 1, 2, 0, 0, 0, 0, 1, 0);
        chk("mw1 EXMEM_write", int'(EXMEM_write), 0);
        cyc(0, 1, 2, 0, 0, 0, 0, 1, 0);
        chk("mw2 busy", int'(busy), 1);
        cyc(0, 1, 2, 0, 0, 0, 0, 1, 0);
        chk("mw3 busy", int'(busy), 1);
        cyc(0, 1, 2, 0, 0, 0, 0, 1, 1);
        chk("mw release busy", int'(busy), 1);
        chk("mw release pc_write", int'(pc_write), 1);
        chk("mw stall_cnt", int'(stall_cnt), 3);
        idle();
        chk("mw after busy", int'(busy), 0);

        // Timeout into ERR, then reset recovers
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 1, 2, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 2, 0, 0, 0, 0, 1, 1);
        chk("to err", int'(err), 1);
        chk("to frozen pc_write", int'(pc_write), 0);
        chk("to MEMWB_flush", int'(MEMWB_flush), 1);
        do_reset();
        idle();
        chk("to rst err", int'(err), 0);
        chk("to rst stall_cnt", int'(stall_cnt), 0);
        chk("to rst pc_write", int'(pc_write), 1);

        // Saturation of stall_cnt
        for (int i = 0; i < 20; i++) cyc(0, 7, 0, 0, 1, 7, 0, 0, 1);
        idle();
        chk("sat stall_cnt", int'(stall_cnt), 15);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int rs_v, rt_v, ert_v;
            bit r_v, req_v;
            rs_v  = int'($urandom_range(0, 3));
            rt_v  = int'($urandom_range(0, 3));
            ert_v = int'($urandom_range(0, 3));
            r_v   = ($urandom_range(0, 59) == 0);
            req_v = ($urandom_range(0, 2) == 0);
            cyc(r_v, rs_v, rt_v, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1), ert_v,
                ($urandom_range(0, 4) == 0), req_v, ($urandom_range(0, 9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
